// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared definitions for the two-port RAM arbiter: sequencing states,
//   default geometry of the 32x16 RAM, default read hold time and the helper
//   that sizes the read-window down-counter.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF   = 5;
   localparam int unsigned DATA_W_DEF   = 16;
   localparam int unsigned READ_CYC_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_READ,
      ST_CAPTURE,
      ST_WRITE
   } state_e;

   // The counter runs READ_CYC-1 down to 0, so it needs clog2(READ_CYC) bits,
   // never fewer than one.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Combinational two-requester round-robin picker.
//   Ports:
//     req0_i, req1_i : request lines
//     last_gnt_i     : index of the port granted most recently
//     gnt_o          : index of the port to grant
//     valid_o        : at least one request is pending
// -----------------------------------------------------------------------------
module rr_arb2 (
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_gnt_i,
   output logic gnt_o,
   output logic valid_o
);

   always_comb begin
      valid_o = req0_i | req1_i;
      if (req0_i && req1_i) begin
         // Tie: favour the port that did not win last time.
         gnt_o = ~last_gnt_i;
      end else begin
         gnt_o = req1_i;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares a single-port synchronous RAM (registered q) between the
//   accumulator datapath (port 0) and the debug/dump path (port 1). Each
//   access is sequenced so the address settles a cycle before wren/rden,
//   stays frozen through the strobe, and rden is held READ_CYC cycles.
//   Ports:
//     clk, reset          : clock, asynchronous active-low reset
//     reqN/weN/addrN/wdataN : request, direction, address, write data (N=0,1)
//     ackN, rdataN        : one-cycle completion pulse, read data for port N
//     mem_address/rden/wren/data, mem_q : RAM interface
//     busy                : sequencer not idle
//     gnt                 : port currently or most recently granted
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned READ_CYC = READ_CYC_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_rden,
   output logic              mem_wren,
   output logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] mem_q,
   output logic              busy,
   output logic              gnt
);

   localparam int unsigned      CNT_W    = cnt_width(READ_CYC);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_CYC - 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                gnt_q, gnt_d;
   logic                last_q, last_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                ack0_q, ack0_d;
   logic                ack1_q, ack1_d;
   logic [DATA_W-1:0]   rdata0_q, rdata0_d;
   logic [DATA_W-1:0]   rdata1_q, rdata1_d;

   logic                arb_gnt;
   logic                arb_valid;

   rr_arb2 u_rr_arb2 (
      .req0_i     (req0),
      .req1_i     (req1),
      .last_gnt_i (last_q),
      .gnt_o      (arb_gnt),
      .valid_o    (arb_valid)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         gnt_q    <= 1'b0;
         last_q   <= 1'b1;
         we_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         gnt_q    <= gnt_d;
         last_q   <= last_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gnt_d    = gnt_q;
      last_d   = last_q;
      we_d     = we_q;
      addr_d   = addr_q;
      data_d   = data_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;

      unique case (state_q)
         ST_IDLE: begin
            // Request fields are captured only here; later changes on the
            // request side do not affect the access in flight.
            if (arb_valid) begin
               gnt_d   = arb_gnt;
               last_d  = arb_gnt;
               we_d    = arb_gnt ? we1    : we0;
               addr_d  = arb_gnt ? addr1  : addr0;
               data_d  = arb_gnt ? wdata1 : wdata0;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            cnt_d   = CNT_LOAD;
            state_d = we_q ? ST_WRITE : ST_READ;
         end
         ST_READ: begin
            if (cnt_q == '0) begin
               state_d = ST_CAPTURE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_CAPTURE: begin
            if (gnt_q) begin
               ack1_d   = 1'b1;
               rdata1_d = mem_q;
            end else begin
               ack0_d   = 1'b1;
               rdata0_d = mem_q;
            end
            state_d = ST_IDLE;
         end
         ST_WRITE: begin
            if (gnt_q) begin
               ack1_d = 1'b1;
            end else begin
               ack0_d = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Strobes decode straight from the state register so a reset drops them
   // without waiting for a clock edge.
   assign mem_rden    = (state_q == ST_READ);
   assign mem_wren    = (state_q == ST_WRITE);
   assign busy        = (state_q != ST_IDLE);
   assign mem_address = addr_q;
   assign mem_data    = data_q;
   assign gnt         = gnt_q;
   assign ack0        = ack0_q;
   assign ack1        = ack1_q;
   assign rdata0      = rdata0_q;
   assign rdata1      = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a behavioural 32x16 registered-output
//   RAM attached to the memory side.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0, req1, we0, we1;
   logic [4:0]  addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic        ack0, ack1;
   logic [15:0] rdata0, rdata1;
   logic [4:0]  mem_address;
   logic        mem_rden, mem_wren;
   logic [15:0] mem_data;
   logic [15:0] mem_q;
   logic        busy, gnt;

   logic [15:0] ram [0:31];
   logic        overlap_seen;

   int n_checks;
   int n_pass;

   mem_arbiter #(
      .ADDR_W   (5),
      .DATA_W   (16),
      .READ_CYC (4)
   ) dut (
      .clk         (clk),
      .reset       (rst_n),
      .req0        (req0),
      .req1        (req1),
      .we0         (we0),
      .we1         (we1),
      .addr0       (addr0),
      .addr1       (addr1),
      .wdata0      (wdata0),
      .wdata1      (wdata1),
      .ack0        (ack0),
      .ack1        (ack1),
      .rdata0      (rdata0),
      .rdata1      (rdata1),
      .mem_address (mem_address),
      .mem_rden    (mem_rden),
      .mem_wren    (mem_wren),
      .mem_data    (mem_data),
      .mem_q       (mem_q),
      .busy        (busy),
      .gnt         (gnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Registered-output RAM model.
   always @(posedge clk) begin
      if (mem_wren) ram[mem_address] <= mem_data;
      if (mem_rden) mem_q <= ram[mem_address];
   end

   initial overlap_seen = 1'b0;
   always @(negedge clk) begin
      if (mem_rden && mem_wren) overlap_seen = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one request, waits (bounded) for its ack, then drops the request.
   // lat is the ack cycle relative to c0, or -1 on timeout.
   task automatic access(input int port, input logic we, input logic [4:0] a,
                         input logic [15:0] d, output logic [15:0] rd, output int lat);
      lat = -1;
      rd  = '0;
      if (port == 0) begin
         req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
      end else begin
         req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
      end
      for (int c = 1; c <= 20; c++) begin
         step();
         if ((port == 0 && ack0) || (port == 1 && ack1)) begin
            lat = c;
            rd  = (port == 0) ? rdata0 : rdata1;
            break;
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      step();
   endtask

   initial begin
      logic [15:0] rd;
      int          lat;

      n_checks = 0;
      n_pass   = 0;
      rst_n  = 1'b0;
      req0   = 1'b0; req1   = 1'b0;
      we0    = 1'b0; we1    = 1'b0;
      addr0  = '0;   addr1  = '0;
      wdata0 = '0;   wdata1 = '0;

      // Reset state.
      #2;
      check("rst_ack0", {31'd0, ack0}, 32'd0);
      check("rst_ack1", {31'd0, ack1}, 32'd0);
      check("rst_rdata0", {16'd0, rdata0}, 32'd0);
      check("rst_rdata1", {16'd0, rdata1}, 32'd0);
      check("rst_addr", {27'd0, mem_address}, 32'd0);
      check("rst_strobes", {30'd0, mem_rden, mem_wren}, 32'd0);
      check("rst_busy_gnt", {30'd0, busy, gnt}, 32'd0);
      step();
      step();
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Read of addr 5 after a port-1 preload.
      access(1, 1'b1, 5'd5, 16'h1234, rd, lat);
      check("pre5_lat", lat, 32'd3);
      req0 = 1'b1; we0 = 1'b0; addr0 = 5'd5;
      for (int c = 1; c <= 7; c++) begin
         step();
         check($sformatf("rd5_rden_c%0d", c), {31'd0, mem_rden}, (c >= 2 && c <= 5) ? 32'd1 : 32'd0);
         check($sformatf("rd5_ack0_c%0d", c), {31'd0, ack0}, (c == 7) ? 32'd1 : 32'd0);
         check($sformatf("rd5_ack1_c%0d", c), {31'd0, ack1}, 32'd0);
         if (mem_rden) check("rd5_addr", {27'd0, mem_address}, 32'd5);
      end
      check("rd5_rdata0", {16'd0, rdata0}, 32'h1234);
      req0 = 1'b0;
      step();
      check("rd5_idle", {31'd0, busy}, 32'd0);

      // Write 31 on port 1, then read it back on port 0.
      req1 = 1'b1; we1 = 1'b1; addr1 = 5'd31; wdata1 = 16'hBEEF;
      step();
      check("wr31_c1_addr", {27'd0, mem_address}, 32'd31);
      check("wr31_c1_wren", {31'd0, mem_wren}, 32'd0);
      check("wr31_c1_data", {16'd0, mem_data}, 32'hBEEF);
      step();
      check("wr31_c2_wren", {31'd0, mem_wren}, 32'd1);
      check("wr31_c2_addr", {27'd0, mem_address}, 32'd31);
      step();
      check("wr31_c3_wren", {31'd0, mem_wren}, 32'd0);
      check("wr31_c3_ack1", {31'd0, ack1}, 32'd1);
      req1 = 1'b0;
      step();
      access(0, 1'b0, 5'd31, 16'h0, rd, lat);
      check("rb31_lat", lat, 32'd7);
      check("rb31_data", {16'd0, rd}, 32'hBEEF);

      // Ties: last grant was port 0, so a tie now goes to port 1; bring the
      // history back to port 1 first with a lone port-1 write.
      access(1, 1'b1, 5'd12, 16'h00CC, rd, lat);
      req0 = 1'b1; we0 = 1'b1; addr0 = 5'd10; wdata0 = 16'h000A;
      req1 = 1'b1; we1 = 1'b1; addr1 = 5'd11; wdata1 = 16'h000B;
      step();
      check("tie1_gnt_first", {31'd0, gnt}, 32'd0);
      step();
      step();
      check("tie1_ack0", {31'd0, ack0}, 32'd1);
      req0 = 1'b0;
      step();
      check("tie1_gnt_second", {31'd0, gnt}, 32'd1);
      step();
      step();
      check("tie1_ack1", {31'd0, ack1}, 32'd1);
      req1 = 1'b0;
      step();
      req0 = 1'b1; req1 = 1'b1;
      step();
      check("tie2_gnt", {31'd0, gnt}, 32'd0);
      step();
      step();
      check("tie2_ack0", {31'd0, ack0}, 32'd1);
      req0 = 1'b0; req1 = 1'b0;
      step();
      req0 = 1'b1; req1 = 1'b1;
      step();
      check("tie3_gnt", {31'd0, gnt}, 32'd1);
      step();
      step();
      check("tie3_ack1", {31'd0, ack1}, 32'd1);
      req0 = 1'b0; req1 = 1'b0;
      step();
      access(0, 1'b0, 5'd10, 16'h0, rd, lat);
      check("tie_mem10", {16'd0, rd}, 32'h000A);
      access(1, 1'b0, 5'd11, 16'h0, rd, lat);
      check("tie_mem11", {16'd0, rd}, 32'h000B);

      // Back-to-back reads of 0,1,2 with req0 held.
      access(1, 1'b1, 5'd0, 16'h0001, rd, lat);
      access(1, 1'b1, 5'd1, 16'h0002, rd, lat);
      access(1, 1'b1, 5'd2, 16'h0003, rd, lat);
      req0 = 1'b1; we0 = 1'b0; addr0 = 5'd0;
      for (int c = 1; c <= 21; c++) begin
         step();
         check($sformatf("b2b_ack0_c%0d", c), {31'd0, ack0}, (c % 7 == 0) ? 32'd1 : 32'd0);
         if (mem_rden) check($sformatf("b2b_addr_c%0d", c), {27'd0, mem_address}, 32'((c - 1) / 7));
         if (c % 7 == 0) begin
            check($sformatf("b2b_rdata_c%0d", c), {16'd0, rdata0}, 32'(c / 7));
            addr0 = 5'(c / 7);
            if (c == 21) req0 = 1'b0;
         end
      end
      step();

      // Reset in c3 of a read.
      access(1, 1'b1, 5'd3, 16'h3333, rd, lat);
      req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
      step();
      step();
      step();
      check("mr_rden_before", {31'd0, mem_rden}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mr_rden", {31'd0, mem_rden}, 32'd0);
      check("mr_busy", {31'd0, busy}, 32'd0);
      check("mr_rdata0", {16'd0, rdata0}, 32'd0);
      check("mr_addr", {27'd0, mem_address}, 32'd0);
      check("mr_data", {16'd0, mem_data}, 32'd0);
      check("mr_gnt", {31'd0, gnt}, 32'd0);
      req0 = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         check("mr_no_ack0", {31'd0, ack0}, 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         check("mr_post_no_ack0", {31'd0, ack0}, 32'd0);
      end
      access(0, 1'b0, 5'd3, 16'h0, rd, lat);
      check("mr_fresh_lat", lat, 32'd7);
      check("mr_fresh_data", {16'd0, rd}, 32'h3333);

      // Request dropped in c1 still completes.
      req0 = 1'b1; we0 = 1'b1; addr0 = 5'd7; wdata0 = 16'h7777;
      step();
      req0 = 1'b0;
      step();
      check("drop_wren", {31'd0, mem_wren}, 32'd1);
      check("drop_addr", {27'd0, mem_address}, 32'd7);
      step();
      check("drop_ack0", {31'd0, ack0}, 32'd1);
      step();
      check("drop_idle", {31'd0, busy}, 32'd0);
      access(1, 1'b0, 5'd7, 16'h0, rd, lat);
      check("drop_mem7", {16'd0, rd}, 32'h7777);

      check("no_overlap", {31'd0, overlap_seen}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port 32x16 synchronous RAM (`Mem`) between two requesters: port 0 is the accumulator datapath and port 1 is the debug/dump path. Each access is sequenced with the timing the RAM and the bench checks demand:
- address stable at least one cycle before `wren` rises;
- `rden` held long enough for a registered-output read;
- address frozen while `wren` is high.

It sits between the requesters and `Mem`, and owns `address`, `rden`, `wren` and `data`.

## Interface
Parameters:
- ADDR_W, 5, RAM address width (32 words)
- DATA_W, 16, RAM word width
- READ_CYC, 4, cycles `mem_rden` is held per read (minimum 2)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request, held until ack
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  ADDR_W  word address; stable while req high
- wdata0 / wdata1  in  DATA_W  write data; stable while req high
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DATA_W  read data, valid in the ack cycle, held until the next read on that port
- mem_address  out  ADDR_W  to `Mem.address`
- mem_rden  out  1  to `Mem.rden`
- mem_wren  out  1  to `Mem.wren`
- mem_data  out  DATA_W  to `Mem.data`
- mem_q  in  DATA_W  from `Mem.q`
- busy  out  1  high in every state except IDLE
- gnt  out  1  index of the port currently or last granted

## Operation
- States are IDLE, SETUP, READ, CAPTURE, WRITE.
- **IDLE**
  - If any req is high, pick a port (see arbitration).
  - Register that port's we/addr/wdata into mem_address/mem_data, set gnt, go to SETUP.
- **SETUP** (1 cycle)
  - Address and data are driven; rden = wren = 0.
  - Next state: READ if we = 0, else WRITE.
- **READ**
  - mem_rden = 1 for exactly READ_CYC cycles, timed by a down-counter.
  - Then go to CAPTURE.
- **CAPTURE** (1 cycle)
  - mem_rden = 0.
  - At the end of the cycle, latch mem_q into rdata[gnt] and set ack[gnt] for the next cycle.
  - Go to IDLE.
- **WRITE** (1 cycle)
  - mem_wren = 1.
  - At the end of the cycle, set ack[gnt] for the next cycle.
  - Go to IDLE.
- **Arbitration** (round-robin)
  - Simultaneous requests go to the port not granted last.
  - A single request is granted regardless of history.
  - The last-grant register resets to 1, so port 0 wins the first tie.
- mem_address and mem_data change only on the IDLE→SETUP edge and otherwise hold their value, including while idle.
- Request fields are sampled only at grant. A req that drops mid-transaction is ignored: the access completes and ack is still pulsed.
- A req still high during its ack cycle is a new request.

## Timing
- Reset values, applied immediately on `reset` low:
  - all outputs are 0, including rdata0/1, mem_address and gnt;
  - last-grant register = 1; state = IDLE.
- A transaction in flight during reset is abandoned: no ack, and `wren` drops asynchronously.
- Cycle numbering: c0 is the cycle in which IDLE samples req.
- Read latency:
  - SETUP in c1;
  - rden high c2..c(1+READ_CYC);
  - CAPTURE in c(2+READ_CYC);
  - ack and rdata in c(3+READ_CYC), i.e. c7 at the default.
- Write latency: SETUP c1, wren high c2, ack c3.
- Throughput:
  - IDLE coincides with the ack cycle, so a pending req is sampled there.
  - Back-to-back reads take 7 cycles each; back-to-back writes take 3.
- Guarantees:
  - wren rises ≥1 cycle after the address change;
  - address constant for the full wren and rden windows;
  - rden and wren are never high together.
- Address 31 is an ordinary address: no wrap logic and no counter carry into the address.

## Structure
- Package `mem_arb_pkg` holds:
  - state enum (IDLE, SETUP, READ, CAPTURE, WRITE);
  - ADDR_W/DATA_W defaults;
  - READ_CYC default;
  - the function giving the READ_CYC counter width.
- Sub-module `rr_arb2`: a combinational two-request round-robin picker taking req0, req1 and last_gnt, returning grant index and valid. The FSM, counter and datapath registers stay in `mem_arbiter`.

## Test plan
- Read: preload mem[5]=16'h1234, pulse req0 read addr 5. Required: rden high c2..c5, ack0 in c7, rdata0=16'h1234, ack1 never asserted.
- Write/readback: req1 write addr 31, data 16'hBEEF. Required: mem_address=31 from c1, wren high only in c2, ack1 in c3. A port-0 read of addr 31 then returns 16'hBEEF.
- Tie: req0 and req1 raised in the same cycle. Required grant order port 0 then port 1. After that, a new tie grants port 0, and a further tie grants port 1.
- Back-to-back: req0 held for 3 reads of addrs 0,1,2 holding 16'h0001/16'h0002/16'h0003. Required: acks in c7, c14, c21 with matching rdata, and mem_address constant within each rden window.
- Reset mid-read: assert reset during c3 of a read. Required: all outputs 0 the same cycle, no ack0. After release, a fresh req0 completes normally.
- Dropped req: req0 write deasserted in c1. Required: the write still executes and ack0 is pulsed in c3.
